// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU sequencer: tag codes, FSM state
// encodings and default widths.
package uart_alu_pkg;

    localparam int DEF_NB_DATA = 8;
    localparam int DEF_NB_OP   = 6;

    // Tag codes as they appear in the low NB_OP bits of a tag byte
    localparam logic [DEF_NB_OP-1:0] TAG_A  = 6'h08;
    localparam logic [DEF_NB_OP-1:0] TAG_B  = 6'h10;
    localparam logic [DEF_NB_OP-1:0] TAG_OP = 6'h20;

    // One-hot sequencer states
    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        WAIT_VAL = 5'b00010,
        EXEC     = 5'b00100,
        TX_START = 5'b01000,
        TX_WAIT  = 5'b10000
    } state_t;

    // Register selected by the most recent valid tag
    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SEL_B  = 2'd1,
        SEL_OP = 2'd2
    } sel_t;

endpackage

// File: rtl/uart_alu_sequencer_timeout.sv
// seq_timeout_counter: counts cycles while enabled and flags when the count
// reaches TIMEOUT_CYCLES-1. Only instantiated when UART_SEQ_TIMEOUT_EN is set.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    assign o_expired = (count_reg == LAST);

    // Count up while enabled; saturate at the terminal value
    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            count_reg <= '0;
        end else if (i_enable && !o_expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: parses tag/value byte pairs from UART RX into the ALU
// operand/opcode registers, fires one ALU evaluation per opcode write and
// hands the result to UART TX.
// Optional build macro: UART_SEQ_TIMEOUT_EN (abandon a frame whose value
// byte does not arrive within TIMEOUT_CYCLES).
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = DEF_NB_DATA,
    parameter int NB_OP          = DEF_NB_OP,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_error,
    output logic               o_overrun
);

    state_t             state_reg, state_next;
    sel_t               sel_reg, sel_next;
    logic [NB_DATA-1:0] a_reg, b_reg, result_reg;
    logic [NB_OP-1:0]   op_reg;

    logic tag_valid;
    sel_t tag_sel;
    logic wr_a, wr_b, wr_op;
    logic error_pulse, overrun_pulse;
    logic timeout_expired;

`ifdef UART_SEQ_TIMEOUT_EN
    // Counter is held clear outside WAIT_VAL so it starts from zero on entry
    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_clear  (state_reg != WAIT_VAL),
        .i_enable (state_reg == WAIT_VAL),
        .o_expired(timeout_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_expired    = 1'b0;
`endif

    // Tag decode: upper bits must be zero and low bits must match exactly
    always_comb begin
        tag_valid = 1'b0;
        tag_sel   = SEL_A;
        if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
            if (i_rx_data[NB_OP-1:0] == NB_OP'(TAG_A)) begin
                tag_valid = 1'b1;
                tag_sel   = SEL_A;
            end else if (i_rx_data[NB_OP-1:0] == NB_OP'(TAG_B)) begin
                tag_valid = 1'b1;
                tag_sel   = SEL_B;
            end else if (i_rx_data[NB_OP-1:0] == NB_OP'(TAG_OP)) begin
                tag_valid = 1'b1;
                tag_sel   = SEL_OP;
            end
        end
    end

    // Next-state, register write enables and status pulses
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        wr_a          = 1'b0;
        wr_b          = 1'b0;
        wr_op         = 1'b0;
        error_pulse   = 1'b0;
        overrun_pulse = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (i_rx_done) begin
                    if (tag_valid) begin
                        sel_next   = tag_sel;
                        state_next = WAIT_VAL;
                    end else begin
                        error_pulse = 1'b1;
                    end
                end
            end
            WAIT_VAL: begin
                // A value byte wins over a timeout in the same cycle
                if (i_rx_done) begin
                    case (sel_reg)
                        SEL_A: begin
                            wr_a       = 1'b1;
                            state_next = IDLE;
                        end
                        SEL_B: begin
                            wr_b       = 1'b1;
                            state_next = IDLE;
                        end
                        SEL_OP: begin
                            wr_op      = 1'b1;
                            state_next = EXEC;
                        end
                        default: state_next = IDLE;
                    endcase
                end else if (timeout_expired) begin
                    error_pulse = 1'b1;
                    state_next  = IDLE;
                end
            end
            EXEC: begin
                overrun_pulse = i_rx_done;
                state_next    = TX_START;
            end
            TX_START: begin
                overrun_pulse = i_rx_done;
                state_next    = TX_WAIT;
            end
            TX_WAIT: begin
                overrun_pulse = i_rx_done;
                if (i_tx_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand, opcode and result registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            sel_reg    <= SEL_A;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            if (wr_a) begin
                a_reg <= i_rx_data;
            end
            if (wr_b) begin
                b_reg <= i_rx_data;
            end
            if (wr_op) begin
                op_reg <= i_rx_data[NB_OP-1:0];
            end
            if (state_reg == EXEC) begin
                result_reg <= i_alu_result;
            end
        end
    end

    assign o_alu_valid  = (state_reg == EXEC);
    assign o_tx_start   = (state_reg == TX_START);
    assign o_busy       = (state_reg != IDLE);
    assign o_tx_data    = result_reg;
    assign o_alu_data_a = a_reg;
    assign o_alu_data_b = b_reg;
    assign o_alu_op     = op_reg;
    assign o_error      = error_pulse;
    assign o_overrun    = overrun_pulse;

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Sequences the shared ALU between the UART receiver and UART transmitter. Parses a tagged byte stream from the RX path into operand A, operand B and opcode registers. On every opcode write it launches one ALU evaluation, captures the result and hands it to the TX path with a start/done handshake. It sits between the UART RX/TX modules and the `alu` instance and is the only block that drives the ALU inputs.

## Interface
- NB_DATA, 8, data/operand/result width
- NB_OP, 6, opcode width; also the width of the tag field
- TIMEOUT_CYCLES, 50000, maximum cycles between a tag byte and its value byte (used only when the timeout feature is compiled in)

Ports (clock and reset first):
- clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when TX finishes the current byte
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- o_tx_data  out  NB_DATA  registered ALU result
- o_alu_valid  out  1  one-cycle ALU evaluate strobe
- o_alu_data_a  out  NB_DATA  operand A register
- o_alu_data_b  out  NB_DATA  operand B register
- o_alu_op  out  NB_OP  opcode register
- i_alu_result  in  NB_DATA  combinational ALU result
- o_busy  out  1  high in every state except IDLE
- o_error  out  1  one-cycle pulse on an unknown tag or a timeout
- o_overrun  out  1  one-cycle pulse when a byte arrives during EXEC/TX_START/TX_WAIT and is dropped

## Operation
- Frame = tag byte then value byte. Tags: 0x08 = A, 0x10 = B, 0x20 = OP. A tag is valid only if bits above NB_OP-1 are zero and its low NB_OP bits match exactly.
- IDLE: on i_rx_done, a valid tag is latched and the block moves to WAIT_VAL. An unknown tag pulses o_error and the block stays in IDLE; the next byte is treated as a tag.
- WAIT_VAL: on i_rx_done, the byte is written to the register selected by the tag.
  - A or B tag: returns to IDLE.
  - OP tag: writes i_rx_data[NB_OP-1:0] to o_alu_op and moves to EXEC.
- EXEC: o_alu_valid=1 for exactly one cycle. i_alu_result is registered into o_tx_data at the end of that cycle. Moves to TX_START.
- TX_START: o_tx_start=1 for one cycle. Moves to TX_WAIT.
- TX_WAIT: holds o_tx_data until i_tx_done, then returns to IDLE.
- Operands A, B and the opcode persist across commands until overwritten. Re-sending only OP re-executes with the old operands.
- Bytes received in EXEC, TX_START or TX_WAIT are dropped and pulse o_overrun. They are never parsed.

## Timing
- Reset values: every output is 0, the state is IDLE, and the operand, opcode and result registers are 0. Reset mid-frame or mid-TX aborts immediately; no o_tx_start is issued afterwards.
- Latency: the OP value byte is sampled at cycle N, o_alu_valid is high at N+1, and o_tx_start is high at N+2. o_tx_data is stable from N+2 until the return to IDLE.
- An i_tx_done seen in any state other than TX_WAIT is ignored.
- If i_rx_done and i_tx_done arrive in the same cycle in TX_WAIT: the block returns to IDLE, the byte is dropped and o_overrun pulses.
- An i_rx_done in the cycle the block enters IDLE from TX_WAIT is not possible. The first byte accepted is the one arriving in the first cycle the block is in IDLE.
- Registered state, one-hot encoded. The next-state logic assigns every signal on every path, with defaults at the top.

## Configuration
- Macro: UART_SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT_VAL and clears on entry. When it reaches TIMEOUT_CYCLES-1 with no i_rx_done, the block pulses o_error, discards the tag and returns to IDLE. If i_rx_done arrives in that same cycle, the byte is accepted normally.
- Not defined: the counter is absent and WAIT_VAL waits indefinitely. TIMEOUT_CYCLES is unused.

## Structure
- Package `uart_alu_pkg`: tag constants (TAG_A, TAG_B, TAG_OP), state encodings (IDLE, WAIT_VAL, EXEC, TX_START, TX_WAIT), and default NB_DATA/NB_OP values.
- One sub-module, `seq_timeout_counter`, instantiated only under UART_SEQ_TIMEOUT_EN.
  - Inputs: clk, i_rst, i_clear, i_enable.
  - Output: o_expired.
  - Parameter: TIMEOUT_CYCLES.
- `alu` is instantiated by the parent and is not instantiated inside this block.

## Test plan
- Send 0x08,0x05 then 0x10,0x03 then 0x20,op_add, with an ALU model returning A+B: o_alu_valid pulses once, o_tx_start pulses 2 cycles after the OP value byte, and o_tx_data=0x08. After i_tx_done: o_busy=0.
- Send 0x20,op_add alone after the previous test: re-executes with A=0x05 and B=0x03, and o_tx_data=0x08 again.
- Send tag 0x0C then bytes 0x08,0x07: one o_error pulse, then A=0x07 and the state returns to IDLE.
- During TX_WAIT, pulse i_rx_done with 0x08 in the same cycle as i_tx_done: o_overrun=1, A unchanged, state IDLE.
- With UART_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, send 0x10 and wait 16 cycles: o_error pulses at cycle 16 and B is unchanged. The same stimulus without the macro: no error, and the block is still in WAIT_VAL after 1000 cycles.
- Assert i_rst during TX_WAIT: all outputs are 0 the next cycle and no o_tx_start follows.
